// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the fetch stage: hart index type and default PC stride.
package cpu_types_pkg;

  // Wide enough for up to 8 hardware threads
  typedef logic [2:0] hart_t;

  localparam int PC_STRIDE_DEF = 4;

endpackage

// File: rtl/multi_hart_pc_if.sv
// Control and fetch bus between hazard/branch resolution and the per-hart PC bank.
interface multi_hart_pc_if #(
  parameter int WIDTH  = 32,
  parameter int NHARTS = 2
);

  localparam int HW = (NHARTS > 1) ? $clog2(NHARTS) : 1;

  logic              stall;
  logic              redirect_valid;
  logic [HW-1:0]     redirect_hart;
  logic [WIDTH-1:0]  redirect_pc;
  logic              exc_valid;
  logic [HW-1:0]     exc_hart;
  logic [WIDTH-1:0]  exc_epc;
  logic              halt_valid;
  logic [HW-1:0]     halt_hart;
  logic [HW-1:0]     epc_rd_hart;
  logic              fetch_valid;
  logic [HW-1:0]     fetch_hart;
  logic [WIDTH-1:0]  fetch_pc;
  logic [WIDTH-1:0]  fetch_npc;
  logic [WIDTH-1:0]  epc_rd;
  logic [NHARTS-1:0] halted;
  logic              all_halted;

  modport master (
    output stall, redirect_valid, redirect_hart, redirect_pc,
           exc_valid, exc_hart, exc_epc, halt_valid, halt_hart, epc_rd_hart,
    input  fetch_valid, fetch_hart, fetch_pc, fetch_npc, epc_rd, halted, all_halted
  );

  modport slave (
    input  stall, redirect_valid, redirect_hart, redirect_pc,
           exc_valid, exc_hart, exc_epc, halt_valid, halt_hart, epc_rd_hart,
    output fetch_valid, fetch_hart, fetch_pc, fetch_npc, epc_rd, halted, all_halted
  );

endinterface

// File: rtl/multi_hart_pc_rr_select.sv
// Rotate-priority scan: picks the first non-halted hart starting at rr_ptr.
module hart_rr_select
  import cpu_types_pkg::*;
#(
  parameter int NHARTS = 2
) (
  input  hart_t             rr_ptr,
  input  logic [NHARTS-1:0] halted,
  output hart_t             sel,
  output logic              any
);

  int idx;

  // Walk rr_ptr, rr_ptr+1, ... modulo NHARTS and keep the first live hart
  always_comb begin
    sel = rr_ptr;
    any = 1'b0;
    idx = 0;
    for (int i = 0; i < NHARTS; i++) begin
      idx = (int'(rr_ptr) + i) % NHARTS;
      if (!any && !halted[idx]) begin
        sel = hart_t'(idx);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_hart_pc.sv
// Per-hart PC bank for the multicore fetch stage: round-robin fetch among
// live harts, exception > redirect > sequential update priority, per-hart EPC.
module multi_hart_pc
  import cpu_types_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               NHARTS      = 2,
  parameter logic [WIDTH-1:0] PC_INIT     = '0,
  parameter logic [WIDTH-1:0] HART_OFFSET = 'h1000,
  parameter int               PC_STRIDE   = PC_STRIDE_DEF,
  parameter logic [WIDTH-1:0] EXC_VECTOR  = 'h80
) (
  input logic           CLK,
  input logic           RST,
  multi_hart_pc_if.slave bus
);

  localparam int HW = (NHARTS > 1) ? $clog2(NHARTS) : 1;
  localparam logic [WIDTH-1:0] STRIDE     = WIDTH'(PC_STRIDE);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~(STRIDE - WIDTH'(1));

  logic [WIDTH-1:0]  pc  [NHARTS];
  logic [WIDTH-1:0]  epc [NHARTS];
  logic [NHARTS-1:0] halted_q;
  hart_t             rr_ptr;
  hart_t             sel;
  logic              any;
  logic              fetch_valid_w;
  logic [WIDTH-1:0]  fetch_pc_w;
  logic [WIDTH-1:0]  fetch_npc_w;
  logic [WIDTH-1:0]  epc_rd_w;

  hart_rr_select #(.NHARTS(NHARTS)) u_select (
    .rr_ptr (rr_ptr),
    .halted (halted_q),
    .sel    (sel),
    .any    (any)
  );

  assign fetch_valid_w = !bus.stall && any;
  assign fetch_npc_w   = fetch_pc_w + STRIDE;

  // Mux the selected hart's PC onto the fetch bus
  always_comb begin
    fetch_pc_w = '0;
    for (int h = 0; h < NHARTS; h++) begin
      if (sel == hart_t'(h)) fetch_pc_w = pc[h];
    end
  end

  // EPC read port; out-of-range selects match no hart and read as zero
  always_comb begin
    epc_rd_w = '0;
    for (int h = 0; h < NHARTS; h++) begin
      if (hart_t'(bus.epc_rd_hart) == hart_t'(h)) epc_rd_w = epc[h];
    end
  end

  // PC/EPC bank, sticky halt flags and round-robin pointer
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int h = 0; h < NHARTS; h++) begin
        pc[h]  <= PC_INIT + WIDTH'(h) * HART_OFFSET;
        epc[h] <= '0;
      end
      halted_q <= '0;
      rr_ptr   <= '0;
    end else begin
      for (int h = 0; h < NHARTS; h++) begin
        if (bus.exc_valid && hart_t'(bus.exc_hart) == hart_t'(h)) begin
          pc[h]  <= EXC_VECTOR;
          epc[h] <= bus.exc_epc;
        end else if (bus.redirect_valid && hart_t'(bus.redirect_hart) == hart_t'(h)) begin
          pc[h] <= bus.redirect_pc & ALIGN_MASK;
        end else if (fetch_valid_w && sel == hart_t'(h)) begin
          pc[h] <= fetch_npc_w;
        end
        if (bus.halt_valid && hart_t'(bus.halt_hart) == hart_t'(h)) begin
          halted_q[h] <= 1'b1;
        end
      end
      if (fetch_valid_w) begin
        rr_ptr <= hart_t'((int'(sel) + 1) % NHARTS);
      end
    end
  end

  assign bus.fetch_valid = fetch_valid_w;
  assign bus.fetch_hart  = HW'(sel);
  assign bus.fetch_pc    = fetch_pc_w;
  assign bus.fetch_npc   = fetch_npc_w;
  assign bus.epc_rd      = epc_rd_w;
  assign bus.halted      = halted_q;
  assign bus.all_halted  = &halted_q;

endmodule

// File: tb/tb_multi_hart_pc.sv
// Scoreboard bench for multi_hart_pc: directed per-cycle vectors push expected
// fetch-bus values; a negedge monitor pops and compares. A second 8-bit
// instance exercises PC wrap-around.
module tb_multi_hart_pc;

  typedef struct {
    logic        valid;
    logic        chk;
    logic        hart;
    logic [31:0] pc;
    logic [31:0] epc;
    logic [1:0]  halted;
  } exp_t;

  logic CLK;
  logic RST;
  logic wrapRst;
  int   errors;
  int   checks;
  exp_t expQ[$];
  exp_t monE;

  multi_hart_pc_if #(.WIDTH(32), .NHARTS(2)) bus ();
  multi_hart_pc_if #(.WIDTH(8),  .NHARTS(2)) wrapBus ();

  multi_hart_pc #(
    .WIDTH(32), .NHARTS(2), .PC_INIT(32'h0), .HART_OFFSET(32'h1000),
    .PC_STRIDE(4), .EXC_VECTOR(32'h80)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  multi_hart_pc #(
    .WIDTH(8), .NHARTS(2), .PC_INIT(8'hFC), .HART_OFFSET(8'h10),
    .PC_STRIDE(4), .EXC_VECTOR(8'h80)
  ) dutWrap (
    .CLK (CLK),
    .RST (wrapRst),
    .bus (wrapBus)
  );

  // Free-running clock, period 10
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Hard stop in case anything hangs
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected during that cycle
  task automatic applyStimulus(
    input logic rst, input logic stall,
    input logic rv, input logic rh, input logic [31:0] rpc,
    input logic ev, input logic eh, input logic [31:0] eepc,
    input logic hv, input logic hh, input logic es,
    input logic xValid, input logic xChk, input logic xHart, input logic [31:0] xPc,
    input logic [31:0] xEpc, input logic [1:0] xHalted);
    exp_t e;
    @(posedge CLK);
    #1;
    RST                = rst;
    bus.stall          = stall;
    bus.redirect_valid = rv;
    bus.redirect_hart  = rh;
    bus.redirect_pc    = rpc;
    bus.exc_valid      = ev;
    bus.exc_hart       = eh;
    bus.exc_epc        = eepc;
    bus.halt_valid     = hv;
    bus.halt_hart      = hh;
    bus.epc_rd_hart    = es;
    e.valid  = xValid;
    e.chk    = xChk;
    e.hart   = xHart;
    e.pc     = xPc;
    e.epc    = xEpc;
    e.halted = xHalted;
    expQ.push_back(e);
  endtask

  // Monitor: compare the DUT's fetch bus against the oldest queued expectation
  always @(negedge CLK) begin
    if (expQ.size() > 0) begin
      monE = expQ.pop_front();
      checkOutput("fetch_valid", 32'(bus.fetch_valid), 32'(monE.valid));
      if (monE.chk) begin
        checkOutput("fetch_hart", 32'(bus.fetch_hart), 32'(monE.hart));
        checkOutput("fetch_pc", bus.fetch_pc, monE.pc);
        checkOutput("fetch_npc", bus.fetch_npc, monE.pc + 32'd4);
      end
      checkOutput("epc_rd", bus.epc_rd, monE.epc);
      checkOutput("halted", 32'(bus.halted), 32'(monE.halted));
      checkOutput("all_halted", 32'(bus.all_halted), 32'(&monE.halted));
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    RST = 1'b1;
    wrapRst = 1'b1;
    bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_hart = 1'b0; bus.redirect_pc = '0;
    bus.exc_valid = 1'b0; bus.exc_hart = 1'b0; bus.exc_epc = '0;
    bus.halt_valid = 1'b0; bus.halt_hart = 1'b0; bus.epc_rd_hart = 1'b0;
    wrapBus.stall = 1'b0; wrapBus.redirect_valid = 1'b0; wrapBus.redirect_hart = 1'b0; wrapBus.redirect_pc = '0;
    wrapBus.exc_valid = 1'b0; wrapBus.exc_hart = 1'b0; wrapBus.exc_epc = '0;
    wrapBus.halt_valid = 1'b0; wrapBus.halt_hart = 1'b0; wrapBus.epc_rd_hart = 1'b0;
    repeat (2) @(posedge CLK);

    // Free-running alternation after reset
    applyStimulus(0,0, 0,0,0, 0,0,0, 0,0,0, 1,1,0,32'h0,    0, 2'b00);
    applyStimulus(0,0, 0,0,0, 0,0,0, 0,0,0, 1,1,1,32'h1000, 0, 2'b00);
    applyStimulus(0,0, 0,0,0, 0,0,0, 0,0,0, 1,1,0,32'h4,    0, 2'b00);
    applyStimulus(0,0, 0,0,0, 0,0,0, 0,0,0, 1,1,1,32'h1004, 0, 2'b00);
    // Three stalled cycles: no fetch, scan result frozen
    repeat (3) applyStimulus(0,1, 0,0,0, 0,0,0, 0,0,0, 0,1,0,32'h8, 0, 2'b00);
    applyStimulus(0,0, 0,0,0, 0,0,0, 0,0,0, 1,1,0,32'h8,    0, 2'b00);
    applyStimulus(0,0, 0,0,0, 0,0,0, 0,0,0, 1,1,1,32'h1008, 0, 2'b00);
    applyStimulus(0,0, 0,0,0, 0,0,0, 0,0,0, 1,1,0,32'hC,    0, 2'b00);
    // Redirect hart1 to an unaligned target while it fetches
    applyStimulus(0,0, 1,1,32'h2003, 0,0,0, 0,0,0, 1,1,1,32'h100C, 0, 2'b00);
    applyStimulus(0,0, 0,0,0, 0,0,0, 0,0,0, 1,1,0,32'h10,   0, 2'b00);
    applyStimulus(0,0, 0,0,0, 0,0,0, 0,0,0, 1,1,1,32'h2000, 0, 2'b00);
    // Exception beats redirect on hart0
    applyStimulus(0,0, 1,0,32'h300, 1,0,32'h10, 0,0,0, 1,1,0,32'h14, 0, 2'b00);
    applyStimulus(0,0, 0,0,0, 0,0,0, 0,0,0, 1,1,1,32'h2004, 32'h10, 2'b00);
    applyStimulus(0,0, 0,0,0, 0,0,0, 0,0,1, 1,1,0,32'h80,   0, 2'b00);
    // Halt hart0, then hart1
    applyStimulus(0,0, 0,0,0, 0,0,0, 1,0,0, 1,1,1,32'h2008, 32'h10, 2'b00);
    applyStimulus(0,0, 0,0,0, 0,0,0, 0,0,0, 1,1,1,32'h200C, 32'h10, 2'b01);
    applyStimulus(0,0, 0,0,0, 0,0,0, 1,1,0, 1,1,1,32'h2010, 32'h10, 2'b01);
    applyStimulus(0,0, 1,0,32'h500, 0,0,0, 0,0,0, 0,0,0,32'h0, 32'h10, 2'b11);
    applyStimulus(0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,32'h0, 32'h10, 2'b11);
    // Reset with exception and halt pending
    applyStimulus(1,0, 0,0,0, 1,1,32'h44, 1,0,0, 0,0,0,32'h0, 32'h10, 2'b11);
    applyStimulus(0,0, 0,0,0, 0,0,0, 0,0,1, 1,1,0,32'h0,    0, 2'b00);
    applyStimulus(0,0, 0,0,0, 0,0,0, 0,0,0, 1,1,1,32'h1000, 0, 2'b00);
    applyStimulus(0,0, 0,0,0, 0,0,0, 0,0,0, 1,1,0,32'h4,    0, 2'b00);

    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge CLK);
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

    // 8-bit instance: hart0 starts at FC, its next PC wraps to 00
    @(posedge CLK);
    #1 wrapRst = 1'b0;
    @(negedge CLK);
    checkOutput("wrap_hart0", 32'(wrapBus.fetch_hart), 32'd0);
    checkOutput("wrap_pc0", 32'(wrapBus.fetch_pc), 32'hFC);
    checkOutput("wrap_npc0", 32'(wrapBus.fetch_npc), 32'h00);
    @(negedge CLK);
    checkOutput("wrap_hart1", 32'(wrapBus.fetch_hart), 32'd1);
    checkOutput("wrap_pc1", 32'(wrapBus.fetch_pc), 32'h0C);
    @(negedge CLK);
    checkOutput("wrap_hart0b", 32'(wrapBus.fetch_hart), 32'd0);
    checkOutput("wrap_pc0b", 32'(wrapBus.fetch_pc), 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
